// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer
//    Initiator for the gcd_machine go/done handshake. Operand pairs arrive over a
//    valid/ready request port and are buffered in a DEPTH-entry FIFO. Each pair is
//    launched into the engine, the sequencer waits for done, and the result is
//    returned over a valid/ready response port. Pairs with a zero operand are
//    answered locally without touching the engine. A job that stays in
//    LAUNCH+WAIT for TIMEOUT cycles is aborted and answered with rsp_timeout=1.
//
// Ports
//    clk, rst_n                 clock (rising edge), asynchronous active-low reset
//    req_valid/req_ready        request handshake, req_ready = FIFO not full
//    req_a, req_b               operand pair
//    gcd_go, gcd_in1, gcd_in2   launch controls to gcd_machine
//    gcd_out, gcd_done          result and completion from gcd_machine
//    rsp_valid/rsp_ready        response handshake
//    rsp_data, rsp_timeout      result (0 when aborted) and abort flag
//    busy                       a job is in service or queued
module gcd_job_sequencer #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             gcd_go,
   output logic [WIDTH-1:0] gcd_in1,
   output logic [WIDTH-1:0] gcd_in2,
   input  logic [WIDTH-1:0] gcd_out,
   input  logic             gcd_done,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_timeout,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, BYPASS, HOLD} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [TW-1:0]    tmo_cnt;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;
   logic             push;
   logic             pop;
   logic             tmo_hit;

   // Full is judged from the registered count only, so a pop in the same
   // cycle never opens a slot for a push.
   assign req_ready = (count != CW'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign busy      = (state != IDLE) || (count != '0);
   assign head_a    = mem_a[rd_ptr];
   assign head_b    = mem_b[rd_ptr];
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

   // FIFO storage: payload only, no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= req_a;
         mem_b[wr_ptr] <= req_b;
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so the pointers
   // wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Job FSM with registered engine and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gcd_go      <= 1'b0;
         gcd_in1     <= '0;
         gcd_in2     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  gcd_in1 <= head_a;
                  gcd_in2 <= head_b;
                  tmo_cnt <= '0;
                  if (head_a == '0 || head_b == '0) begin
                     state <= BYPASS;
                  end else begin
                     state  <= LAUNCH;
                     gcd_go <= 1'b1;
                  end
               end
            end
            LAUNCH: begin
               // done may still be high from the previous job (or from reset);
               // keep go asserted until the engine drops it.
               if (tmo_hit) begin
                  gcd_go      <= 1'b0;
                  rsp_data    <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= HOLD;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (!gcd_done) begin
                     gcd_go <= 1'b0;
                     state  <= WAIT;
                  end
               end
            end
            WAIT: begin
               // A completion on the last allowed cycle still wins over abort.
               if (gcd_done) begin
                  rsp_data    <= gcd_out;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= HOLD;
               end else if (tmo_hit) begin
                  rsp_data    <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= HOLD;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            BYPASS: begin
               // gcd(0,x) = x; gcd(0,0) falls out as 0.
               rsp_data    <= (gcd_in1 == '0) ? gcd_in2 : gcd_in1;
               rsp_timeout <= 1'b0;
               rsp_valid   <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer
//    Directed bench for gcd_job_sequencer with a behavioural gcd_machine and a
//    transaction-level model (job queue + in-service job) checked every cycle.
module tb_gcd_job_sequencer;

   localparam int W   = 32;
   localparam int DEP = 4;
   localparam int TMO = 16;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         tmo;
   } job_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         gcd_go;
   logic [W-1:0] gcd_in1;
   logic [W-1:0] gcd_in2;
   logic [W-1:0] gcd_out;
   logic         gcd_done;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         rsp_timeout;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   gcd_job_sequencer #(.WIDTH(W), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .gcd_go(gcd_go), .gcd_in1(gcd_in1), .gcd_in2(gcd_in2),
      .gcd_out(gcd_out), .gcd_done(gcd_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Behavioural gcd_machine: done high when idle (also out of reset), accepts
   // go only while done, one Euclid step per cycle. stuck freezes a job,
   // abort forces it back to idle/done.
   logic         stuck = 1'b0;
   logic         abort = 1'b0;
   logic         eng_run;
   logic [W-1:0] eng_x, eng_y;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcd_done <= 1'b1;
         eng_run  <= 1'b0;
         gcd_out  <= '0;
         eng_x    <= '0;
         eng_y    <= '0;
      end else if (abort) begin
         gcd_done <= 1'b1;
         eng_run  <= 1'b0;
      end else if (!eng_run && gcd_go && gcd_done) begin
         eng_x    <= gcd_in1;
         eng_y    <= gcd_in2;
         gcd_done <= 1'b0;
         eng_run  <= 1'b1;
      end else if (eng_run && !stuck) begin
         if (eng_y == 0) begin
            gcd_out  <= eng_x;
            gcd_done <= 1'b1;
            eng_run  <= 1'b0;
         end else begin
            eng_x <= eng_y;
            eng_y <= eng_x % eng_y;
         end
      end
   end

   // Transaction model: queued jobs, the job in service, and the response log.
   job_t         jq[$];
   job_t         cur;
   bit           in_service = 0;
   bit           drop_seen = 0;
   logic         req_tmo = 1'b0;
   logic [W-1:0] rlog[$];
   logic         tlog[$];
   int           go_cycles = 0;

   initial forever begin
      @(negedge rst_n);
      jq.delete();
      in_service = 0;
      drop_seen  = 0;
   end

   initial forever begin
      bit   do_acc, do_pop;
      job_t nj;
      @(posedge clk);
      if (rst_n) begin
         do_acc = req_valid && (jq.size() < DEP);
         do_pop = !in_service && (jq.size() > 0);
         if (in_service && gcd_go && !gcd_done) drop_seen = 1;
         if (rsp_valid && rsp_ready) begin
            rlog.push_back(rsp_data);
            tlog.push_back(rsp_timeout);
            in_service = 0;
         end
         if (do_pop) begin
            cur        = jq.pop_front();
            in_service = 1;
            drop_seen  = 0;
         end
         if (do_acc) begin
            nj.a   = req_a;
            nj.b   = req_b;
            nj.tmo = req_tmo;
            jq.push_back(nj);
         end
      end
   end

   initial forever begin
      logic exp_go;
      @(negedge clk);
      if (gcd_go) go_cycles++;
      if (rst_n) begin
         chk("req_ready", req_ready, (jq.size() < DEP));
         chk("busy", busy, (in_service || jq.size() != 0));
         exp_go = in_service && cur.a != 0 && cur.b != 0 && !drop_seen && !rsp_valid;
         chk("gcd_go", gcd_go, exp_go);
         if (in_service) begin
            chk("gcd_in1", gcd_in1, cur.a);
            chk("gcd_in2", gcd_in2, cur.b);
         end
         if (rsp_valid) begin
            chk("rsp_owner", in_service, 1);
            if (in_service) begin
               chk("rsp_data", rsp_data, cur.tmo ? '0 : gcd_ref(cur.a, cur.b));
               chk("rsp_timeout", rsp_timeout, cur.tmo);
            end
         end
      end
   end

   // Stimulus helpers; all called and returning on a falling edge.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic tmo);
      int n = 0;
      req_a = a;
      req_b = b;
      req_tmo = tmo;
      req_valid = 1'b1;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("push_wait", (n < 300), 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", (n < 400), 1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("valid_wait", (n < 100), 1);
   endtask

   task automatic chk_log(input string name, input int idx, input logic [W-1:0] exp);
      if (idx < rlog.size()) chk(name, rlog[idx], exp);
      else chk({name, "_missing"}, 0, 1);
   endtask

   initial begin
      int k, go0;
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, go0;
      // Reset values while rst_n is low.
      #2 rst_n = 1'b0;
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gcd_go", gcd_go, 0);
      chk("rst_gcd_in1", gcd_in1, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rel_req_ready", req_ready, 1);

      // Single job through the engine.
      rsp_ready = 1'b1;
      rlog.delete(); tlog.delete();
      push(16, 42, 0);
      wait_idle();
      chk_log("t1_rsp", 0, 2);
      chk("t1_busy", busy, 0);

      // Fill the FIFO behind a held response, then drain in order.
      rsp_ready = 1'b0;
      rlog.delete(); tlog.delete();
      push(12, 18, 0);
      push(35, 14, 0);
      push(9, 28, 0);
      push(100, 75, 0);
      push(7, 7, 0);
      fork
         push(8, 12, 0);
         begin
            repeat (4) @(negedge clk);
            chk("t2_full", req_ready, 0);
            rsp_ready = 1'b1;
         end
      join
      wait_idle();
      chk_log("t2_rsp0", 0, 6);
      chk_log("t2_rsp1", 1, 7);
      chk_log("t2_rsp2", 2, 1);
      chk_log("t2_rsp3", 3, 25);
      chk_log("t2_rsp4", 4, 7);
      chk_log("t2_rsp5", 5, 4);

      // Zero-operand jobs bypass the engine.
      rlog.delete(); tlog.delete();
      go0 = go_cycles;
      push(0, 21, 0);
      push(21, 0, 0);
      push(0, 0, 0);
      wait_idle();
      chk_log("t3_rsp0", 0, 21);
      chk_log("t3_rsp1", 1, 21);
      chk_log("t3_rsp2", 2, 0);
      chk("t3_no_go", go_cycles - go0, 0);

      // Stuck engine: abort after TIMEOUT cycles, then a normal job.
      rsp_ready = 1'b0;
      rlog.delete(); tlog.delete();
      stuck = 1'b1;
      push(5, 10, 1);
      n = 0;
      while (!gcd_go && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_go_seen", (n < 20), 1);
      k = 0;
      while (!rsp_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("t4_tmo_latency", k, TMO);
      chk("t4_tmo_flag", rsp_timeout, 1);
      chk("t4_tmo_data", rsp_data, 0);
      stuck = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      push(48, 36, 0);
      rsp_ready = 1'b1;
      wait_idle();
      chk_log("t4_rsp0", 0, 0);
      chk_log("t4_rsp1", 1, 12);
      if (tlog.size() > 1) begin
         chk("t4_tlog0", tlog[0], 1);
         chk("t4_tlog1", tlog[1], 0);
      end else chk("t4_tlog_missing", 0, 1);

      // Response held for 10+ cycles: stable, FIFO fills, no new launch.
      rsp_ready = 1'b0;
      rlog.delete(); tlog.delete();
      push(8, 12, 0);
      wait_valid();
      go0 = go_cycles;
      push(3, 9, 0);
      push(4, 6, 0);
      push(15, 25, 0);
      push(14, 21, 0);
      repeat (6) @(negedge clk);
      chk("t5_full", req_ready, 0);
      chk("t5_valid", rsp_valid, 1);
      chk("t5_data", rsp_data, 4);
      chk("t5_no_go", go_cycles - go0, 0);
      rsp_ready = 1'b1;
      wait_idle();
      chk_log("t5_rsp0", 0, 4);
      chk_log("t5_rsp1", 1, 3);
      chk_log("t5_rsp2", 2, 2);
      chk_log("t5_rsp3", 3, 5);
      chk_log("t5_rsp4", 4, 7);

      // Reset while waiting on the engine with two jobs queued.
      rsp_ready = 1'b0;
      rlog.delete(); tlog.delete();
      stuck = 1'b1;
      push(40, 24, 1);
      push(6, 9, 0);
      push(10, 4, 0);
      @(negedge clk);
      chk("t6_in_wait_go", gcd_go, 0);
      chk("t6_in_wait_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_go", gcd_go, 0);
      chk("t6_rst_in1", gcd_in1, 0);
      chk("t6_rst_in2", gcd_in2, 0);
      chk("t6_rst_valid", rsp_valid, 0);
      chk("t6_rst_data", rsp_data, 0);
      chk("t6_rst_tmo", rsp_timeout, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      stuck = 1'b0;
      rsp_ready = 1'b1;
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("t6_no_rsp", rlog.size(), 0);
      chk("t6_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
